core_dispatcher: RTL

Sequences one render job across the videocard's CORE_NUM shader cores. It takes a start command with a core mask and sends a one-cycle start pulse to the selected cores. It then collects each core's sticky completion and raises a single level interrupt when all selected cores are done or a watchdog expires. The interrupt stays high until acknowledged. It sits between the host/command path and the cores, as the sequencing owner of the core completion-to-interrupt path.

---
 rtl/core_dispatcher.sv | 127 ++++++++++++
 1 files changed

// File: rtl/core_dispatcher.sv
// Render-job dispatcher: pulses start to a set of shader cores, gathers their
// completions and raises a held interrupt on all-done or watchdog expiry.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no job; waiting for start with a non-empty core mask
// LAUNCH | one cycle; core_start pulses for the latched mask
// WAIT   | collecting core_done; watchdog counts down if enabled
// IRQ    | interrupt held (timed_out qualifies it) until irq_ack
module core_dispatcher #(
    parameter int CORE_NUM  = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CORE_NUM-1:0]  core_mask,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic [CORE_NUM-1:0]  core_start,
    input  logic [CORE_NUM-1:0]  core_done,
    output logic                 busy,
    output logic                 interrupt,
    input  logic                 irq_ack,
    output logic                 timed_out,
    output logic [CORE_NUM-1:0]  done_status
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_IRQ    = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [CORE_NUM-1:0]  mask_q, mask_nxt;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_nxt;
    logic [CORE_NUM-1:0]  core_start_nxt;
    logic [CORE_NUM-1:0]  done_status_nxt;
    logic [CORE_NUM-1:0]  done_acc;
    logic                 busy_nxt;
    logic                 interrupt_nxt;
    logic                 timed_out_nxt;
    logic                 all_done;
    logic                 cnt_tc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            mask_q      <= '0;
            cnt_q       <= '0;
            core_start  <= '0;
            busy        <= 1'b0;
            interrupt   <= 1'b0;
            timed_out   <= 1'b0;
            done_status <= '0;
        end else begin
            state       <= state_nxt;
            mask_q      <= mask_nxt;
            cnt_q       <= cnt_nxt;
            core_start  <= core_start_nxt;
            busy        <= busy_nxt;
            interrupt   <= interrupt_nxt;
            timed_out   <= timed_out_nxt;
            done_status <= done_status_nxt;
        end
    end

    always_comb begin
        done_acc        = done_status | (core_done & mask_q);
        all_done        = (done_acc == mask_q);
        cnt_tc          = (cnt_q == TIMEOUT_W'(1));

        state_nxt       = state;
        mask_nxt        = mask_q;
        cnt_nxt         = cnt_q;
        core_start_nxt  = '0;
        busy_nxt        = busy;
        interrupt_nxt   = interrupt;
        timed_out_nxt   = timed_out;
        done_status_nxt = done_status;

        case (state)
            S_IDLE: begin
                // Registering the LAUNCH-cycle values here keeps every output a flop.
                if (start && (core_mask != '0)) begin
                    state_nxt       = S_LAUNCH;
                    mask_nxt        = core_mask;
                    cnt_nxt         = timeout_cycles;
                    core_start_nxt  = core_mask;
                    busy_nxt        = 1'b1;
                    done_status_nxt = '0;
                end
            end
            S_LAUNCH: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                done_status_nxt = done_acc;
                // Completion outranks a watchdog hitting terminal count in the same cycle.
                if (all_done) begin
                    state_nxt     = S_IRQ;
                    interrupt_nxt = 1'b1;
                    timed_out_nxt = 1'b0;
                end else if (cnt_tc) begin
                    state_nxt     = S_IRQ;
                    interrupt_nxt = 1'b1;
                    timed_out_nxt = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - TIMEOUT_W'(1);
                end
            end
            S_IRQ: begin
                if (irq_ack) begin
                    state_nxt     = S_IDLE;
                    interrupt_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                    timed_out_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
